// File: rtl/lsb_evt_pkg.sv
// Shared field layout and register map for the lsb_evt input-change event stage.
package lsb_evt_pkg;

    // Event word field positions
    localparam int VALID    = 31;
    localparam int OVF      = 30;
    localparam int TS_HI    = 29;
    localparam int TS_LO    = 16;
    localparam int CHG_HI   = 15;
    localparam int CHG_LO   = 8;
    localparam int LVL_HI   = 7;
    localparam int LVL_LO   = 0;

    // Control/status bit positions
    localparam int FLUSH    = 31;
    localparam int IRQ_EN   = 12;
    localparam int COUNT_HI = 11;
    localparam int COUNT_LO = 8;
    localparam int MASK_HI  = 7;
    localparam int MASK_LO  = 0;

    localparam int EVT_WIDTH = 31;

    typedef enum logic {
        ADR_EVT  = 1'b0,
        ADR_CTRL = 1'b1
    } adr_e;

    // Stored event word; the valid bit is added when the head is read out.
    typedef struct packed {
        logic        ovf;
        logic [13:0] ts;
        logic [7:0]  chg;
        logic [7:0]  lvl;
    } evt_t;

endpackage

// File: rtl/lsb_evt_fifo.sv
// Synchronous circular-buffer FIFO with flush; flush overrides push and pop.
module evt_fifo #(
    parameter int depth = 8,
    parameter int width = 31,
    localparam int AW = $clog2(depth),
    localparam int CW = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_acc;
    logic             push_acc;

    assign empty    = (count == '0);
    assign full     = (count == CW'(depth));
    assign pop_acc  = pop && !empty;
    // A full FIFO still accepts a push when a slot is freed in the same cycle.
    assign push_acc = push && (!full || pop_acc);
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_acc && !pop_acc) begin
                count <= count + CW'(1);
            end else if (!push_acc && pop_acc) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lsb_evt.sv
// Button/switch change capture: timestamped events queued in a FIFO, read over the IO bus.
module lsb_evt
    import lsb_evt_pkg::*;
#(
    parameter int depth    = 8,
    parameter int ts_width = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        adr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        tick,
    input  logic [3:0]  btn,
    input  logic [3:0]  swi,
    output logic        irq
);

    localparam int CW = $clog2(depth + 1);

    logic [7:0]          in8;
    logic [7:0]          prev;
    logic [7:0]          chg;
    logic [7:0]          en_mask;
    logic                init;
    logic                ovf;
    logic                irq_en;
    logic [ts_width-1:0] ts;
    logic                evt;
    logic                rd_evt;
    logic                rd_ctrl;
    logic                wr_ctrl;
    logic                flush;
    logic                drop;
    evt_t                word;
    logic [EVT_WIDTH-1:0] head;
    logic [CW-1:0]       fcount;
    logic [3:0]          count4;
    logic                full;
    logic                empty;
    logic                unused_bits;

    assign in8     = {swi, btn};
    assign chg     = (in8 ^ prev) & en_mask;
    assign evt     = !init && (chg != '0);
    assign rd_evt  = stb && !we && (adr == ADR_EVT);
    assign rd_ctrl = stb && !we && (adr == ADR_CTRL);
    assign wr_ctrl = stb && we && (adr == ADR_CTRL);
    assign flush   = wr_ctrl && data_in[FLUSH];
    assign drop    = evt && full && !(rd_evt && !empty);
    assign count4  = 4'(fcount);
    assign ack     = stb;

    assign unused_bits = ^{data_in[30:13], data_in[11:8]};

    always_comb begin
        word     = '0;
        word.ovf = ovf;
        word.ts  = ts;
        word.chg = chg;
        word.lvl = in8;
    end

    evt_fifo #(
        .depth (depth),
        .width (EVT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt),
        .pop   (rd_evt),
        .flush (flush),
        .din   (word),
        .dout  (head),
        .count (fcount),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            init    <= 1'b1;
            en_mask <= '0;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            ts      <= '0;
            irq     <= 1'b0;
        end else begin
            prev <= in8;
            init <= 1'b0;
            if (tick) begin
                ts <= ts + ts_width'(1);
            end
            if (wr_ctrl) begin
                en_mask <= data_in[MASK_HI:MASK_LO];
                irq_en  <= data_in[IRQ_EN];
            end
            if (flush) begin
                ovf <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
            irq <= irq_en && (fcount != '0);
        end
    end

    always_comb begin
        data_out = '0;
        if (rd_evt && !empty) begin
            data_out[VALID]           = 1'b1;
            data_out[OVF:LVL_LO]      = head;
        end else if (rd_ctrl) begin
            data_out[OVF + 1]             = ovf;
            data_out[IRQ_EN]              = irq_en;
            data_out[COUNT_HI:COUNT_LO]   = count4;
            data_out[MASK_HI:MASK_LO]     = en_mask;
        end
    end

endmodule

// File: tb/tb_lsb_evt.sv
// Directed bench for lsb_evt with a queue-based reference model checked every cycle.
module tb_lsb_evt;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic        adr;
    logic        tick;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;
    logic [3:0]  btn;
    logic [3:0]  swi;

    int n_cmp = 0;
    int n_bad = 0;

    lsb_evt #(
        .depth    (DEPTH),
        .ts_width (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .adr      (adr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .tick     (tick),
        .btn      (btn),
        .swi      (swi),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: event list as a queue, state as plain variables.
    logic [31:0] mq[$];
    bit          m_ovf    = 1'b0;
    bit          m_init   = 1'b1;
    bit          m_irq_en = 1'b0;
    bit          m_irq    = 1'b0;
    int          m_ts     = 0;
    logic [7:0]  m_prev   = '0;
    logic [7:0]  m_mask   = '0;
    logic [7:0]  m_in8;
    logic [7:0]  m_chg;
    logic [31:0] m_word;
    logic [31:0] m_exp;
    bit          m_evt;
    bit          m_pop;
    bit          m_wrc;
    int          m_sz;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                mq.delete();
                m_ovf = 0; m_init = 1; m_irq_en = 0; m_irq = 0;
                m_ts = 0; m_prev = '0; m_mask = '0;
            end else begin
                m_sz  = mq.size();
                m_exp = '0;
                if (stb && !we) begin
                    if (!adr) m_exp = (m_sz > 0) ? mq[0] : 32'h0;
                    else      m_exp = {m_ovf, 18'b0, m_irq_en, 4'(m_sz), m_mask};
                end
                chk("data_out", data_out, m_exp);
                chk("ack", {31'b0, ack}, {31'b0, stb});
                chk("irq", {31'b0, irq}, {31'b0, m_irq});

                m_in8  = {swi, btn};
                m_chg  = (m_in8 ^ m_prev) & m_mask;
                m_evt  = !m_init && (m_chg != 0);
                m_pop  = stb && !we && !adr && (m_sz > 0);
                m_wrc  = stb && we && adr;
                m_word = {1'b1, m_ovf, 14'(m_ts), m_chg, m_in8};
                m_irq  = m_irq_en && (m_sz != 0);
                if (m_wrc && data_in[31]) begin
                    mq.delete();
                    m_ovf = 0;
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (m_evt) begin
                        if (mq.size() < DEPTH) mq.push_back(m_word);
                        else m_ovf = 1;
                    end
                end
                if (m_wrc) begin
                    m_mask   = data_in[7:0];
                    m_irq_en = data_in[12];
                end
                m_ts   = (m_ts + int'(tick)) % 16384;
                m_prev = m_in8;
                m_init = 0;
            end
        end
    end

    task automatic cyc(input bit s, input bit w, input bit a, input logic [31:0] d, input bit t);
        @(negedge clk);
        stb = s; we = w; adr = a; data_in = d; tick = t;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; stb = 0; we = 0; adr = 0; data_in = 0; tick = 0;
        btn = 4'b0101; swi = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 0;

        // Quiet inputs after reset give no events
        cyc(1, 0, 1, 0, 0); #2;
        chk("reset_status", data_out, 32'h0000_0000);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        cyc(1, 1, 1, 32'h0000_10FF, 0);
        repeat (100) idle();
        cyc(1, 0, 1, 0, 0); #2;
        chk("quiet_status", data_out, 32'h0000_10FF);
        cyc(1, 0, 0, 0, 0); #2;
        chk("quiet_read", data_out, 32'h0000_0000);
        chk("quiet_irq", {31'b0, irq}, 32'h0);

        // Single event after 5 ticks
        cyc(1, 1, 1, 32'h0000_1000, 0);
        idle(); btn = 4'b0000;
        idle(); idle();
        repeat (5) begin cyc(0, 0, 0, 0, 1); idle(); end
        cyc(1, 1, 1, 32'h0000_10FF, 0);
        idle(); btn = 4'b0001;
        cyc(1, 0, 1, 0, 0); #2;
        chk("one_status", data_out, 32'h0000_11FF);
        chk("irq_lag", {31'b0, irq}, 32'h0);
        idle(); #2;
        chk("irq_set", {31'b0, irq}, 32'h1);
        cyc(1, 0, 0, 0, 0); #2;
        chk("first_event", data_out, 32'h8005_0101);
        idle(); #2;
        chk("irq_hold", {31'b0, irq}, 32'h1);
        idle(); #2;
        chk("irq_clear", {31'b0, irq}, 32'h0);

        // Mask filtering and multi-bit event
        cyc(1, 1, 1, 32'h0000_100F, 0);
        idle(); swi = 4'b0001;
        idle();
        cyc(1, 0, 1, 0, 0); #2;
        chk("masked_status", data_out, 32'h0000_100F);
        idle(); btn = 4'b1011;
        cyc(1, 0, 0, 0, 0); #2;
        chk("multi_event", data_out, 32'h8005_0A1B);

        // Overflow: nine events into eight slots
        cyc(1, 1, 1, 32'h0000_10FF, 0);
        repeat (9) begin idle(); btn[0] = ~btn[0]; end
        cyc(1, 0, 1, 0, 0); #2;
        chk("full_ovf", data_out, 32'h8000_18FF);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 0); #2;
            chk("drain_flags", {30'b0, data_out[31:30]}, 32'd2);
        end

        // Full FIFO: push coinciding with pop is accepted
        cyc(1, 1, 1, 32'h8000_10FF, 0);
        repeat (8) begin idle(); btn[0] = ~btn[0]; end
        cyc(1, 0, 1, 0, 0); #2;
        chk("refill", data_out, 32'h0000_18FF);
        cyc(1, 0, 0, 0, 0); btn[0] = ~btn[0];
        cyc(1, 0, 1, 0, 0); #2;
        chk("push_on_pop", data_out, 32'h0000_18FF);

        // Flush beats a simultaneous push
        cyc(1, 1, 1, 32'h8000_10FF, 0); btn[0] = ~btn[0];
        cyc(1, 0, 1, 0, 0); #2;
        chk("flush_wins", data_out, 32'h0000_10FF);
        idle(); #2;
        chk("irq_after_flush", {31'b0, irq}, 32'h0);

        // Reset mid-operation discards pending events
        repeat (2) begin idle(); btn[0] = ~btn[0]; end
        idle(); rst = 1; btn[0] = ~btn[0];
        idle(); rst = 0; btn[0] = ~btn[0];
        cyc(1, 0, 1, 0, 0); #2;
        chk("reset_midop", data_out, 32'h0000_0000);

        // Timestamp: same-cycle tick uses old value, then wrap to 0
        cyc(1, 1, 1, 32'h0000_10FF, 0);
        for (int i = 0; i < 16384; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (i == 3) btn[0] = ~btn[0];
        end
        idle(); btn[0] = ~btn[0];
        cyc(1, 0, 0, 0, 0); #2;
        chk("ts_with_tick", {18'b0, data_out[29:16]}, 32'd3);
        cyc(1, 0, 0, 0, 0); #2;
        chk("ts_wrap", {18'b0, data_out[29:16]}, 32'd0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsb_evt.md
Name: lsb_evt

Overview:
- Event capture stage downstream of the LEDs/switches/buttons block.
- Consumes the debounced, clock-synchronous button and switch levels (btn_out/swi_out) and detects per-input level changes.
- Stores each change as a timestamped event word in a small FIFO, read by software over the same single-address IO bus style.
- Raises an interrupt while events are pending, so software need not poll.

Parameters:
- depth, 8, FIFO entries; power of two, 2..16.
- ts_width, 14, timestamp counter width in tick units; must be 14 to fit the event word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stb  in  1  IO strobe; each cycle with stb high is one access
- we  in  1  write enable (1 = write, 0 = read)
- adr  in  1  register select: 0 = event FIFO, 1 = control/status
- data_in  in  32  write data
- data_out  out  32  read data; 0 when not reading
- ack  out  1  equals stb (zero wait states)
- tick  in  1  one-cycle timebase pulse (e.g. 1 ms)
- btn  in  4  debounced button levels
- swi  in  4  debounced switch levels
- irq  out  1  interrupt request, level

Behaviour:
- Input vector: in8 = {swi[3:0], btn[3:0]}.
- Register prev[7:0] is loaded with in8 every cycle.
- Flag init is set by reset and cleared on the first cycle after reset. While init is 1, prev loads but no event is generated, so static input levels after reset produce no events.
- Change mask: chg = (in8 ^ prev) & en_mask.
  - chg != 0 in cycle n → one event pushed at the end of cycle n, visible to a read from cycle n+1.
  - Simultaneous changes on several inputs form one event.
- Event word: [31] valid = 1, [30] ovf flag at push time, [29:16] ts, [15:8] chg, [7:0] in8.
- Timestamp:
  - ts counts tick pulses, width ts_width, wraps from 2^14-1 to 0.
  - An event pushed in the same cycle as a tick carries the pre-increment value.
- FIFO: circular buffer with rd_ptr, wr_ptr and count (0..depth).
  - Push is accepted if count < depth, or if a pop happens in the same cycle.
  - Push refused when full without a pop: the event is dropped and sticky ovf is set.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo depth.
- Read adr 0 (stb & ~we & adr==0):
  - data_out = head entry, combinationally in the same cycle.
  - If count > 0, pop at the clock edge.
  - If empty, data_out = 0 (valid = 0) and no pop.
- Read adr 1: data_out = {ovf, 18'b0, irq_en, count[3:0], en_mask[7:0]}, i.e. [31] ovf, [12] irq_en, [11:8] count, [7:0] en_mask.
- Write adr 1:
  - en_mask <= data_in[7:0]; irq_en <= data_in[12].
  - If data_in[31] = 1: flush FIFO (pointers and count to 0) and clear ovf.
  - Flush in the same cycle as a push: flush wins, the event is lost, ovf stays clear.
  - The new en_mask applies from the next cycle.
- Write adr 0: ignored.
- irq = irq_en & (count != 0), registered (updates one cycle after count changes).
- Reset values: en_mask = 0 (capture disabled), irq_en = 0, ovf = 0, count = 0, pointers = 0, ts = 0, prev = 0, init = 1, irq = 0. data_out = 0 and ack = 0 while stb is low.
- Reset mid-operation: all pending events are discarded; no event is generated for the reset cycle or the first cycle after it.
- ovf is stored in each later event so software can locate the loss point.

Decomposition:
- Shared package constants:
  - Event word field positions: VALID = 31, OVF = 30, TS = 29:16, CHG = 15:8, LVL = 7:0.
  - Control/status bit positions: FLUSH = 31, IRQ_EN = 12, COUNT = 11:8, MASK = 7:0.
  - Register select values: ADR_EVT = 0, ADR_CTRL = 1.
- One natural sub-module: evt_fifo (synchronous FIFO: push, pop, flush, dout, count, full, empty; parameters depth and width = 31). It holds the word without the valid bit; valid is generated at the output.

Test Plan:
- Reset with btn = 4'b0101, then en_mask = 8'hFF and irq_en = 1; no input change for 100 cycles → count = 0, irq = 0, adr-0 read = 32'h0.
- After 5 ticks, btn goes 0000→0001 → one event. adr-0 read = 32'h8005_0101, i.e. valid = 1, ts = 5, chg = 8'h01, lvl = 8'h01. irq high one cycle after the push, low one cycle after the pop.
- en_mask = 8'h0F, then swi[0] toggles → no event. btn[3] and btn[1] change in the same cycle → single event with chg = 8'h0A.
- Push 9 events with depth = 8 → count = 8 and status bit 31 = 1. Read 8 entries in push order: the 9th event is lost, and entries 1-8 carry ovf = 0.
- FIFO full, input change coincides with an adr-0 read → push accepted, count stays 8, ovf stays 0.
- Write adr 1 with 32'h8000_10FF while an input changes in the same cycle → count = 0, ovf = 0, irq = 0 next cycle. Timestamp wrap: 16384 ticks after ts = 0 → the next event carries ts = 0.
